// File: rtl/seq_comparator.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : seq_comparator
// Purpose  : Multi-cycle chunked comparator (EQ/NE/LT/GE/LTU/GEU) with a
//            start/busy/done handshake. Optional macro SEQ_CMP_EARLY_EXIT_EN
//            ends the operation at the first differing chunk.
// Revision : 1.0 - initial release
// ============================================================================
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] C_IDX_TOP = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] C_IDX_ONE = IDXW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    logic [0:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [2:0]       op_q,      op_d;
    logic [IDXW-1:0]  idx_q,     idx_d;
    logic             decided_q, decided_d;
    logic             lt_q,      lt_d;
    logic [WIDTH-1:0] r_q,       r_d;
    logic             done_q,    done_d;

    logic             w_signed;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_a_adj;
    logic [WIDTH-1:0] w_b_adj;
    logic [CHUNK-1:0] w_a_chunks [NCHUNK];
    logic [CHUNK-1:0] w_b_chunks [NCHUNK];
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_diff;
    logic             w_last;
    logic             w_finish;
    logic             w_decided_nx;
    logic             w_lt_nx;
    logic             w_eq;
    logic             w_res_bit;

    // Flipping the operand sign bits maps two's-complement order onto
    // unsigned order, so one magnitude compare serves both kinds of op.
    assign w_signed = (op_q == OP_LT) || (op_q == OP_GE);
    assign w_flip   = {w_signed, {(WIDTH-1){1'b0}}};
    assign w_a_adj  = a_q ^ w_flip;
    assign w_b_adj  = b_q ^ w_flip;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_a_chunks[gi] = w_a_adj[gi*CHUNK +: CHUNK];
            assign w_b_chunks[gi] = w_b_adj[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_chunk = w_a_chunks[idx_q];
    assign w_b_chunk = w_b_chunks[idx_q];
    assign w_diff    = (w_a_chunk != w_b_chunk);
    assign w_last    = (idx_q == '0);

    // Only the first differing chunk (most significant) sets the ordering.
    assign w_decided_nx = decided_q | w_diff;
    assign w_lt_nx      = decided_q ? lt_q : (w_diff & (w_a_chunk < w_b_chunk));

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_finish = w_last | w_diff;
`else
    assign w_finish = w_last;
`endif

    assign w_eq = ~w_decided_nx;

    always_comb begin
        w_res_bit = 1'b0;
        case (op_q)
            OP_EQ:          w_res_bit = w_eq;
            OP_NE:          w_res_bit = ~w_eq;
            OP_LT, OP_LTU:  w_res_bit = w_lt_nx;
            OP_GE, OP_GEU:  w_res_bit = ~w_lt_nx;
            default:        w_res_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        r_d       = r_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    op_d      = op;
                    idx_d     = C_IDX_TOP;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                decided_d = w_decided_nx;
                lt_d      = w_lt_nx;
                if (w_finish) begin
                    r_d     = {{(WIDTH-1){1'b0}}, w_res_bit};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q - C_IDX_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            r_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            r_q       <= r_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = done_q;
    assign R    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_seq_comparator
// Purpose  : Scoreboard bench for seq_comparator against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_comparator;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [2:0]       op = 3'b000;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;

    seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        int               lat;
        int               acc;
        string            tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] o);
        logic bit_r;
        case (o)
            3'd0:    bit_r = (a == b);
            3'd1:    bit_r = (a != b);
            3'd2:    bit_r = ($signed(a) <  $signed(b));
            3'd3:    bit_r = ($signed(a) >= $signed(b));
            3'd4:    bit_r = (a <  b);
            3'd5:    bit_r = (a >= b);
            default: bit_r = 1'b0;
        endcase
        return WIDTH'(bit_r);
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        logic [WIDTH-1:0] mask;
        int j;
        mask = WIDTH'((1 << CHUNK) - 1);
        j = 1;
        for (int i = NCHUNK - 1; i > 0; i--) begin
            if (((a >> (i*CHUNK)) & mask) == ((b >> (i*CHUNK)) & mask)) j++;
            else break;
        end
        return j;
`else
        return NCHUNK + 0 * int'(a ^ b);
`endif
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_R"}, 32'(R), 32'(mon_e.r));
                check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4*NCHUNK) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", tag, 4*NCHUNK);
        end
    endtask

    // Called just after a negedge; returns at the negedge where done is seen,
    // so consecutive calls issue start during the done cycle.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] o, input string tag, input bit intrude);
        exp_t e;
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        e.r = ref_r(a, b, o); e.lat = ref_lat(a, b); e.acc = cyc; e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); op = 3'($urandom);
        if (intrude) begin
            start = 1'b1;
            A = ~a; B = b ^ 16'h00F0; op = o ^ 3'b001;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] sa, sb, ra, rb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_R", 32'(R), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        issue(16'h1234, 16'h1234, 3'b000, "eq_same", 1'b0);
        issue(16'h1234, 16'h1234, 3'b001, "ne_same", 1'b0);
        issue(16'hFFFF, 16'h0001, 3'b010, "lt_neg", 1'b0);
        issue(16'hFFFF, 16'h0001, 3'b100, "ltu_big", 1'b0);
        issue(16'hFFFF, 16'h0001, 3'b011, "ge_neg", 1'b0);
        issue(16'hFFFF, 16'h0001, 3'b101, "geu_big", 1'b0);
        issue(16'h1235, 16'h1234, 3'b100, "ltu_low", 1'b0);
        issue(16'h1235, 16'h1234, 3'b101, "geu_low", 1'b0);
        issue(16'h1235, 16'h1234, 3'b000, "eq_low", 1'b0);
        issue(16'h8000, 16'h7FFF, 3'b010, "lt_minmax", 1'b0);
        issue(16'hA5A5, 16'hA5A5, 3'b000, "intrude_eq", 1'b1);
        issue(16'h0005, 16'h0005, 3'b110, "rsvd6", 1'b0);
        issue(16'h0003, 16'h0009, 3'b111, "rsvd7", 1'b0);

        sa = 16'h1234; sb = 16'h1234;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) sa = sa + 1'b1;
            else            sb = sb + 1'b1;
            issue(sa, sb, 3'b000, "sweep_eq", 1'b0);
            issue(sa, sb, 3'b001, "sweep_ne", 1'b0);
            issue(sa, sb, 3'b100, "sweep_ltu", 1'b0);
        end

        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (CHUNK * $urandom_range(0, NCHUNK-1)));
                default: rb = WIDTH'($urandom);
            endcase
            issue(ra, rb, 3'($urandom_range(0, 7)), "rnd", 1'b0);
        end

        // Asynchronous reset in the middle of an operation.
        issue(16'h4444, 16'h4444, 3'b000, "pre_rst", 1'b0);
        A = 16'h1111; B = 16'h1111; op = 3'b000; start = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_R", 32'(R), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0100, 16'h0200, 3'b100, "post_rst", 1'b0);

        @(negedge clk);
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
